// File: rtl/i2c_pkg.sv
// ---------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the write-only I2C target:
//   - i2c_state_e       : receive FSM state encoding
//   - ACK / NACK        : SDA level seen by the master during the 9th clock
//   - I2C_RW_WRITE      : R/W bit value of a master write
//   - GENERAL_CALL_ADDR : reserved broadcast address
//   - addr_is_write_to(): address-byte decode helper
// ---------------------------------------------------------------------------
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_ADDR_ACK = 3'd2,
        ST_DATA     = 3'd3,
        ST_DATA_ACK = 3'd4,
        ST_IGNORE   = 3'd5
    } i2c_state_e;

    localparam logic       ACK               = 1'b0;
    localparam logic       NACK              = 1'b1;
    localparam logic       I2C_RW_WRITE      = 1'b0;
    localparam logic [6:0] GENERAL_CALL_ADDR = 7'h00;

    // True when the address byte {addr, rw} is a write aimed at target_addr.
    function automatic logic addr_is_write_to(input logic [6:0] addr,
                                              input logic       rw,
                                              input logic [6:0] target_addr);
        return (addr == target_addr) && (rw == I2C_RW_WRITE);
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// ---------------------------------------------------------------------------
// i2c_line_sync
// Brings one asynchronous bus line into the logic_clk domain.
// SYNC_STAGES flops (preset to 1 = idle bus level) followed by one history
// flop, so rise/fall are single-cycle strobes aligned with the synced level.
// Both SCL and SDA use this block, giving them identical latency, which is
// what makes START/STOP detection (SDA edge while SCL high) trustworthy.
// Ports:
//   clk     in  : system clock
//   rst_n   in  : asynchronous active-low reset
//   line_in in  : raw bus line
//   level   out : synchronized level
//   rise    out : one-cycle strobe on synced 0->1
//   fall    out : one-cycle strobe on synced 1->0
// SYNC_STAGES must be at least 2.
// ---------------------------------------------------------------------------
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   hist_r;

    // Synchronizer chain plus one-cycle history of the synced level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= {SYNC_STAGES{1'b1}};
            hist_r <= 1'b1;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], line_in};
            hist_r <= sync_r[SYNC_STAGES-1];
        end
    end

    assign level = sync_r[SYNC_STAGES-1];
    assign rise  = sync_r[SYNC_STAGES-1] & ~hist_r;
    assign fall  = ~sync_r[SYNC_STAGES-1] & hist_r;

endmodule

// File: rtl/i2c_slave_rx.sv
// ---------------------------------------------------------------------------
// i2c_slave_rx
// Write-only I2C target. Oversamples SCL/SDA on logic_clk_in, detects
// START / repeated START / STOP, matches SLAVE_ADDR (write only), ACKs the
// address and every byte it can hand downstream, and NACKs (and flags
// overflow) a byte arriving while rx_ready_in is low. Never stretches SCL.
// Ports:
//   logic_clk_in  in    : system clock (>= 16x SCL)
//   reset_n_in    in    : asynchronous active-low reset
//   i2c_scl_in    in    : bus SCL
//   i2c_sda_inout inout : bus SDA, driven 0 or z only
//   data_out      out   : last accepted data byte
//   data_valid    out   : one-cycle pulse when data_out is new
//   rx_ready_in   in    : downstream can accept a byte
//   addr_match    out   : addressed, from address ACK until STOP/restart
//   busy          out   : bus transaction in progress (START..STOP)
//   overflow      out   : sticky, a byte was NACKed for lack of rx_ready_in
//   gen_call      out   : only with I2C_SLAVE_GENERAL_CALL_EN; transaction
//                         was opened by the general-call address
// Optional build macro: I2C_SLAVE_GENERAL_CALL_EN (also ACK address 7'h00).
// ---------------------------------------------------------------------------
module i2c_slave_rx
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = 7'h55,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       logic_clk_in,
    input  logic       reset_n_in,
    input  logic       i2c_scl_in,
    inout  wire        i2c_sda_inout,
    output logic [7:0] data_out,
    output logic       data_valid,
    input  logic       rx_ready_in,
    output logic       addr_match,
    output logic       busy,
    output logic       overflow
`ifdef I2C_SLAVE_GENERAL_CALL_EN
    ,
    output logic       gen_call
`endif
);

    logic scl_lvl_s, scl_rise_s, scl_fall_s;
    logic sda_lvl_s, sda_rise_s, sda_fall_s;
    logic start_s, stop_s;
    logic own_hit_s, gc_hit_s;
    logic sda_oe_s;
    logic [7:0] byte_s;

    i2c_state_e state_r, state_nxt;
    logic [2:0] bit_cnt_r, bit_cnt_nxt;
    logic [7:0] shift_r, shift_nxt;
    logic [7:0] data_out_r, data_out_nxt;
    logic       data_valid_r, data_valid_nxt;
    logic       addr_match_r, addr_match_nxt;
    logic       busy_r, busy_nxt;
    logic       overflow_r, overflow_nxt;
    logic       sda_drive_r, sda_drive_nxt;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
        .clk     (logic_clk_in),
        .rst_n   (reset_n_in),
        .line_in (i2c_scl_in),
        .level   (scl_lvl_s),
        .rise    (scl_rise_s),
        .fall    (scl_fall_s)
    );

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
        .clk     (logic_clk_in),
        .rst_n   (reset_n_in),
        .line_in (i2c_sda_inout),
        .level   (sda_lvl_s),
        .rise    (sda_rise_s),
        .fall    (sda_fall_s)
    );

    assign start_s   = sda_fall_s & scl_lvl_s;
    assign stop_s    = sda_rise_s & scl_lvl_s;
    // Complete byte as it would look after this sampling edge.
    assign byte_s    = {shift_r[6:0], sda_lvl_s};
    assign own_hit_s = addr_is_write_to(shift_r[6:0], sda_lvl_s, SLAVE_ADDR);
`ifdef I2C_SLAVE_GENERAL_CALL_EN
    assign gc_hit_s  = addr_is_write_to(shift_r[6:0], sda_lvl_s, GENERAL_CALL_ADDR);
`else
    assign gc_hit_s  = 1'b0;
`endif

    // Bus conditions gate the drive directly so SDA lets go in the very
    // cycle a START/STOP is recognised, not one cycle later.
    assign sda_oe_s      = sda_drive_r & ~start_s & ~stop_s;
    assign i2c_sda_inout = sda_oe_s ? ACK : 1'bz;

    // Next-state and next-output logic; START/STOP override bit handling.
    always_comb begin
        state_nxt      = state_r;
        bit_cnt_nxt    = bit_cnt_r;
        shift_nxt      = shift_r;
        data_out_nxt   = data_out_r;
        data_valid_nxt = 1'b0;
        addr_match_nxt = addr_match_r;
        busy_nxt       = busy_r;
        overflow_nxt   = overflow_r;
        sda_drive_nxt  = sda_drive_r;

        if (stop_s) begin
            state_nxt      = ST_IDLE;
            busy_nxt       = 1'b0;
            addr_match_nxt = 1'b0;
            sda_drive_nxt  = 1'b0;
            bit_cnt_nxt    = 3'd0;
        end else if (start_s) begin
            // Covers both a fresh START and a repeated START.
            state_nxt      = ST_ADDR;
            busy_nxt       = 1'b1;
            overflow_nxt   = 1'b0;
            addr_match_nxt = 1'b0;
            sda_drive_nxt  = 1'b0;
            bit_cnt_nxt    = 3'd0;
            shift_nxt      = 8'h00;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    sda_drive_nxt = 1'b0;
                end
                ST_ADDR: begin
                    if (scl_rise_s) begin
                        shift_nxt = byte_s;
                        if (bit_cnt_r == 3'd7) begin
                            bit_cnt_nxt = 3'd0;
                            if (own_hit_s || gc_hit_s) begin
                                state_nxt      = ST_ADDR_ACK;
                                addr_match_nxt = 1'b1;
                            end else begin
                                state_nxt = ST_IGNORE;
                            end
                        end else begin
                            bit_cnt_nxt = bit_cnt_r + 3'd1;
                        end
                    end else begin
                        shift_nxt = shift_r;
                    end
                end
                ST_ADDR_ACK, ST_DATA_ACK: begin
                    // First SCL fall after bit 8 starts the ACK; the next
                    // fall (end of 9th clock) ends it.
                    if (scl_fall_s) begin
                        if (sda_drive_r) begin
                            sda_drive_nxt = 1'b0;
                            state_nxt     = ST_DATA;
                            bit_cnt_nxt   = 3'd0;
                        end else begin
                            sda_drive_nxt = 1'b1;
                        end
                    end else begin
                        sda_drive_nxt = sda_drive_r;
                    end
                end
                ST_DATA: begin
                    if (scl_rise_s) begin
                        shift_nxt = byte_s;
                        if (bit_cnt_r == 3'd7) begin
                            bit_cnt_nxt = 3'd0;
                            if (rx_ready_in) begin
                                data_out_nxt   = byte_s;
                                data_valid_nxt = 1'b1;
                                state_nxt      = ST_DATA_ACK;
                            end else begin
                                // SDA stays released: the master sees NACK.
                                overflow_nxt = 1'b1;
                                state_nxt    = ST_IGNORE;
                            end
                        end else begin
                            bit_cnt_nxt = bit_cnt_r + 3'd1;
                        end
                    end else begin
                        shift_nxt = shift_r;
                    end
                end
                ST_IGNORE: begin
                    sda_drive_nxt = 1'b0;
                end
                default: begin
                    state_nxt     = ST_IDLE;
                    sda_drive_nxt = 1'b0;
                    busy_nxt      = 1'b0;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge logic_clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_r      <= ST_IDLE;
            bit_cnt_r    <= 3'd0;
            shift_r      <= 8'h00;
            data_out_r   <= 8'h00;
            data_valid_r <= 1'b0;
            addr_match_r <= 1'b0;
            busy_r       <= 1'b0;
            overflow_r   <= 1'b0;
            sda_drive_r  <= 1'b0;
        end else begin
            state_r      <= state_nxt;
            bit_cnt_r    <= bit_cnt_nxt;
            shift_r      <= shift_nxt;
            data_out_r   <= data_out_nxt;
            data_valid_r <= data_valid_nxt;
            addr_match_r <= addr_match_nxt;
            busy_r       <= busy_nxt;
            overflow_r   <= overflow_nxt;
            sda_drive_r  <= sda_drive_nxt;
        end
    end

    assign data_out   = data_out_r;
    assign data_valid = data_valid_r;
    assign addr_match = addr_match_r;
    assign busy       = busy_r;
    assign overflow   = overflow_r;

`ifdef I2C_SLAVE_GENERAL_CALL_EN
    logic gen_call_r;

    // Marks a transaction opened by the general-call address until it ends.
    always_ff @(posedge logic_clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            gen_call_r <= 1'b0;
        end else if (stop_s || start_s) begin
            gen_call_r <= 1'b0;
        end else if ((state_r == ST_ADDR) && scl_rise_s && (bit_cnt_r == 3'd7) && gc_hit_s) begin
            gen_call_r <= 1'b1;
        end else begin
            gen_call_r <= gen_call_r;
        end
    end

    assign gen_call = gen_call_r;
`endif

endmodule

// File: tb/tb_i2c_slave_rx.sv
module tb_i2c_slave_rx;

    localparam int Q = 8; // logic clocks per quarter SCL period (SCL = 32 clocks)

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       scl      = 1'b1;
    logic       sda_low  = 1'b0;
    logic       rx_ready = 1'b1;
    wire        sda_bus;
    logic [7:0] data_out;
    logic       data_valid, addr_match, busy, overflow;
`ifdef I2C_SLAVE_GENERAL_CALL_EN
    logic       gen_call;
`endif

    int         checks = 0;
    int         errors = 0;
    logic [7:0] rx_q[$];
    logic       tgt_drove = 1'b0;
    logic       ack;

    always #5 clk = ~clk;

    assign sda_bus = sda_low ? 1'b0 : 1'bz;
    pullup (sda_bus);

    i2c_slave_rx #(.SLAVE_ADDR(7'h55), .SYNC_STAGES(2)) dut (
        .logic_clk_in  (clk),
        .reset_n_in    (rst_n),
        .i2c_scl_in    (scl),
        .i2c_sda_inout (sda_bus),
        .data_out      (data_out),
        .data_valid    (data_valid),
        .rx_ready_in   (rx_ready),
        .addr_match    (addr_match),
        .busy          (busy),
        .overflow      (overflow)
`ifdef I2C_SLAVE_GENERAL_CALL_EN
        ,
        .gen_call      (gen_call)
`endif
    );

    // Record every delivered byte.
    always @(posedge clk) if (rst_n && data_valid) rx_q.push_back(data_out);

    // Bus low while the master releases it means the target is driving.
    always @(negedge clk) if (!sda_low && sda_bus === 1'b0) tgt_drove = 1'b1;

    task automatic wait_q();
        repeat (Q) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        sda_low = 1'b0; wait_q();
        scl = 1'b1;     wait_q();
        sda_low = 1'b1; wait_q();
        scl = 1'b0;     wait_q();
    endtask

    task automatic i2c_stop();
        sda_low = 1'b1; wait_q();
        scl = 1'b1;     wait_q();
        sda_low = 1'b0; wait_q();
        wait_q();
    endtask

    task automatic clock_bit(input logic b);
        sda_low = ~b; wait_q();
        scl = 1'b1;   wait_q();
        wait_q();
        scl = 1'b0;   wait_q();
    endtask

    task automatic ack_bit(output logic a);
        sda_low = 1'b0; wait_q();
        scl = 1'b1;     wait_q();
        a = sda_bus;    wait_q();
        scl = 1'b0;     wait_q();
    endtask

    task automatic send_byte(input logic [7:0] v, output logic a);
        for (int i = 7; i >= 0; i--) clock_bit(v[i]);
        ack_bit(a);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out: got %h expected %h", data_out, 8'h00); end
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_data_valid: got %b expected 0", data_valid); end
        checks++; if (addr_match !== 1'b0) begin errors++; $display("FAIL reset_addr_match: got %b expected 0", addr_match); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        checks++; if (sda_bus !== 1'b1) begin errors++; $display("FAIL reset_sda: got %b expected 1", sda_bus); end
        rst_n = 1'b1;
        wait_q();
    endtask

    task automatic test_single_write();
        rx_q.delete();
        rx_ready = 1'b1;
        i2c_start();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_start: got %b expected 1", busy); end
        send_byte(8'hAA, ack);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL single_addr_ack: got %b expected 0", ack); end
        checks++; if (addr_match !== 1'b1) begin errors++; $display("FAIL single_addr_match: got %b expected 1", addr_match); end
        send_byte(8'hAA, ack);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL single_data_ack: got %b expected 0", ack); end
        checks++; if (rx_q.size() != 1) begin errors++; $display("FAIL single_dv_count: got %0d expected 1", rx_q.size()); end
        else if (rx_q[0] !== 8'hAA) begin errors++; $display("FAIL single_dv_byte: got %h expected aa", rx_q[0]); end
        checks++; if (data_out !== 8'hAA) begin errors++; $display("FAIL single_data_out: got %h expected aa", data_out); end
        i2c_stop();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_stop: got %b expected 0", busy); end
        checks++; if (addr_match !== 1'b0) begin errors++; $display("FAIL single_match_stop: got %b expected 0", addr_match); end
    endtask

    task automatic test_two_bytes();
        rx_q.delete();
        i2c_start();
        send_byte(8'hAA, ack);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL two_addr_ack: got %b expected 0", ack); end
        send_byte(8'h01, ack);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL two_b0_ack: got %b expected 0", ack); end
        checks++; if (addr_match !== 1'b1) begin errors++; $display("FAIL two_match_b0: got %b expected 1", addr_match); end
        send_byte(8'hD3, ack);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL two_b1_ack: got %b expected 0", ack); end
        checks++; if (addr_match !== 1'b1) begin errors++; $display("FAIL two_match_b1: got %b expected 1", addr_match); end
        i2c_stop();
        checks++; if (rx_q.size() != 2) begin errors++; $display("FAIL two_dv_count: got %0d expected 2", rx_q.size()); end
        else if (rx_q[0] !== 8'h01 || rx_q[1] !== 8'hD3) begin errors++; $display("FAIL two_dv_order: got %h %h expected 01 d3", rx_q[0], rx_q[1]); end
    endtask

    task automatic test_other_addr();
        rx_q.delete();
        i2c_start();
        tgt_drove = 1'b0;
        send_byte(8'h54, ack); // 7'h2A, write
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL other_addr_nack: got %b expected 1", ack); end
        send_byte(8'h33, ack);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL other_data_nack: got %b expected 1", ack); end
        checks++; if (tgt_drove !== 1'b0) begin errors++; $display("FAIL other_sda_driven: got %b expected 0", tgt_drove); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL other_busy: got %b expected 1", busy); end
        checks++; if (addr_match !== 1'b0) begin errors++; $display("FAIL other_addr_match: got %b expected 0", addr_match); end
        i2c_stop();
        checks++; if (rx_q.size() != 0) begin errors++; $display("FAIL other_dv_count: got %0d expected 0", rx_q.size()); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL other_busy_stop: got %b expected 0", busy); end
    endtask

    task automatic test_overflow();
        rx_q.delete();
        rx_ready = 1'b1;
        i2c_start();
        send_byte(8'hAA, ack);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL ovf_addr_ack: got %b expected 0", ack); end
        rx_ready = 1'b0;
        send_byte(8'h01, ack);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL ovf_data_nack: got %b expected 1", ack); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", overflow); end
        checks++; if (rx_q.size() != 0) begin errors++; $display("FAIL ovf_dv_count: got %0d expected 0", rx_q.size()); end
        i2c_stop();
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
        rx_ready = 1'b1;
        i2c_start();
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear_start: got %b expected 0", overflow); end
        i2c_stop();
    endtask

    task automatic test_restart();
        rx_q.delete();
        i2c_start();
        send_byte(8'hAA, ack);
        clock_bit(1'b1); clock_bit(1'b0); clock_bit(1'b1); clock_bit(1'b0);
        i2c_start();
        checks++; if (addr_match !== 1'b0) begin errors++; $display("FAIL rs_addr_match: got %b expected 0", addr_match); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rs_busy: got %b expected 1", busy); end
        send_byte(8'hAA, ack);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rs_addr_ack: got %b expected 0", ack); end
        send_byte(8'h5A, ack);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rs_data_ack: got %b expected 0", ack); end
        i2c_stop();
        checks++; if (rx_q.size() != 1) begin errors++; $display("FAIL rs_dv_count: got %0d expected 1", rx_q.size()); end
        else if (rx_q[0] !== 8'h5A) begin errors++; $display("FAIL rs_dv_byte: got %h expected 5a", rx_q[0]); end
    endtask

    task automatic test_reset_mid();
        rx_q.delete();
        i2c_start();
        for (int i = 7; i >= 0; i--) clock_bit(((8'hAA >> i) & 8'h01) != 8'h00);
        // 9th clock of the address byte: target should be holding SDA low
        sda_low = 1'b0; wait_q();
        scl = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        checks++; if (sda_bus !== 1'b0) begin errors++; $display("FAIL mid_ack_driven: got %b expected 0", sda_bus); end
        rst_n = 1'b0;
        #1;
        checks++; if (sda_bus !== 1'b1) begin errors++; $display("FAIL mid_sda_release: got %b expected 1", sda_bus); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", busy); end
        checks++; if (addr_match !== 1'b0) begin errors++; $display("FAIL mid_addr_match: got %b expected 0", addr_match); end
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL mid_data_out: got %h expected 00", data_out); end
        checks++; if (data_valid !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL mid_dv_ovf: got %b%b expected 00", data_valid, overflow); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_q();
        scl = 1'b0; wait_q();
        i2c_stop();
        i2c_start();
        send_byte(8'hAA, ack);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL mid_re_addr_ack: got %b expected 0", ack); end
        send_byte(8'hAA, ack);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL mid_re_data_ack: got %b expected 0", ack); end
        i2c_stop();
        checks++; if (rx_q.size() != 1) begin errors++; $display("FAIL mid_re_dv_count: got %0d expected 1", rx_q.size()); end
        else if (rx_q[0] !== 8'hAA) begin errors++; $display("FAIL mid_re_dv_byte: got %h expected aa", rx_q[0]); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_two_bytes();
        test_other_addr();
        test_overflow();
        test_restart();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
